// File: rtl/jt12_regfile_q.sv
// Per-slot FM register store: operator and channel records fed by a ready/valid
// write queue, streamed one slot per cycle to the PG/EG/OP pipeline.
module jt12_regfile_q #(
  parameter int CHANNELS = 6,
  parameter int QDEPTH   = 4,
  parameter int CHW      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [CHW-1:0]  wr_ch,
  input  logic [1:0]      wr_op,
  input  logic [3:0]      wr_field,
  input  logic [7:0]      wr_data,
  output logic            busy,
  output logic            out_zero,
  output logic [4:0]      out_slot,
  output logic [43:0]     op_out,
  output logic [26:0]     ch_out
);

  localparam int SLOTS  = 4 * CHANNELS;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [3:0] {
    F_DT1_MUL  = 4'd0,
    F_TL       = 4'd1,
    F_KS_AR    = 4'd2,
    F_AM_D1R   = 4'd3,
    F_D2R      = 4'd4,
    F_D1L_RR   = 4'd5,
    F_SSG      = 4'd6,
    F_FNUM_LO  = 4'd8,
    F_BLK_FNUM = 4'd9,
    F_FB_ALG   = 4'd10,
    F_RL_AMS   = 4'd11
  } field_e;

  typedef struct packed {
    logic [2:0] dt1;
    logic [3:0] mul;
    logic [6:0] tl;
    logic [1:0] ks;
    logic [4:0] ar;
    logic       amen;
    logic [4:0] d1r;
    logic [4:0] d2r;
    logic [3:0] d1l;
    logic [3:0] rr;
    logic       ssg_en;
    logic [2:0] ssg_eg;
  } op_rec_t;

  typedef struct packed {
    logic [2:0]  block;
    logic [10:0] fnum;
    logic [2:0]  fb;
    logic [2:0]  alg;
    logic [1:0]  rl;
    logic [1:0]  ams;
    logic [2:0]  pms;
  } ch_rec_t;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [1:0]     op;
    logic [3:0]     field;
    logic [7:0]     data;
  } wr_req_t;

  // Write queue
  wr_req_t          r_q [QDEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic    w_full, w_empty, w_push, w_pop;
  wr_req_t w_head;

  assign w_full   = (r_count == CNT_W'(QDEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = wr_valid & ~w_full;
  assign w_head   = r_q[r_rd_ptr];
  assign wr_ready = ~w_full;
  assign busy     = ~w_empty;

  // NOTE: queue storage is not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr_ptr] <= {wr_ch, wr_op, wr_field, wr_data};
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head decode and commit
  logic [4:0]     r_cur;
  logic [CHW-1:0] r_cur_ch;
  logic           w_field_op, w_field_ch, w_ch_ok, w_req_ok, w_hit;
  logic           w_commit_op, w_commit_ch;
  logic [4:0]     w_target;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_field_op = 1'b0;
    w_field_ch = 1'b0;
    case (w_head.field)
      F_DT1_MUL, F_TL, F_KS_AR, F_AM_D1R, F_D2R, F_D1L_RR, F_SSG: w_field_op = 1'b1;
      F_FNUM_LO, F_BLK_FNUM, F_FB_ALG, F_RL_AMS:                  w_field_ch = 1'b1;
      default: ;
    endcase
  end

  assign w_ch_ok  = (int'(w_head.ch) < CHANNELS);
  assign w_req_ok = w_ch_ok & (w_field_op | w_field_ch);
  // Channel fields live at the op0 slot of their channel, which is slot == ch
  assign w_target = w_field_ch ? 5'(w_head.ch)
                               : 5'(w_head.op) * 5'(CHANNELS) + 5'(w_head.ch);
  assign w_hit       = (w_target == r_cur);
  assign w_pop       = ~w_empty & (~w_req_ok | w_hit);
  assign w_commit_op = ~w_empty & w_req_ok & w_field_op & w_hit;
  assign w_commit_ch = ~w_empty & w_req_ok & w_field_ch & w_hit;

  // Records; a commit always targets the record at cur, so one merge serves both write and read
  op_rec_t r_op [SLOTS];
  ch_rec_t r_ch [CHANNELS];
  op_rec_t w_op_new;
  ch_rec_t w_ch_new;
  logic [7:0] w_d;

  assign w_d = w_head.data;

  always_comb begin
    w_op_new = r_op[r_cur[SLOT_W-1:0]];
    if (w_commit_op) begin
      case (w_head.field)
        F_DT1_MUL: begin w_op_new.dt1 = w_d[6:4]; w_op_new.mul = w_d[3:0]; end
        F_TL:      w_op_new.tl = w_d[6:0];
        F_KS_AR:   begin w_op_new.ks = w_d[7:6]; w_op_new.ar = w_d[4:0]; end
        F_AM_D1R:  begin w_op_new.amen = w_d[7]; w_op_new.d1r = w_d[4:0]; end
        F_D2R:     w_op_new.d2r = w_d[4:0];
        F_D1L_RR:  begin w_op_new.d1l = w_d[7:4]; w_op_new.rr = w_d[3:0]; end
        F_SSG:     begin w_op_new.ssg_en = w_d[3]; w_op_new.ssg_eg = w_d[2:0]; end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_ch_new = r_ch[r_cur_ch];
    if (w_commit_ch) begin
      case (w_head.field)
        F_FNUM_LO:  w_ch_new.fnum[7:0] = w_d;
        F_BLK_FNUM: begin w_ch_new.block = w_d[5:3]; w_ch_new.fnum[10:8] = w_d[2:0]; end
        F_FB_ALG:   begin w_ch_new.fb = w_d[5:3]; w_ch_new.alg = w_d[2:0]; end
        F_RL_AMS:   begin w_ch_new.rl = w_d[7:6]; w_ch_new.ams = w_d[5:4]; w_ch_new.pms = w_d[2:0]; end
        default: ;
      endcase
    end
  end

  // Records are cleared by reset so a mid-operation reset leaves a clean voice state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++)    r_op[i] <= '0;
      for (int i = 0; i < CHANNELS; i++) r_ch[i] <= '0;
    end else begin
      if (w_commit_op) r_op[r_cur[SLOT_W-1:0]] <= w_op_new;
      if (w_commit_ch) r_ch[r_cur_ch]          <= w_ch_new;
    end
  end

  // Slot counter and registered read port
  logic [4:0]  r_out_slot;
  logic        r_out_zero;
  logic [43:0] r_op_out;
  logic [26:0] r_ch_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur      <= '0;
      r_cur_ch   <= '0;
      r_out_slot <= '0;
      r_out_zero <= 1'b1;
      r_op_out   <= '0;
      r_ch_out   <= '0;
    end else begin
      r_cur      <= (r_cur == 5'(SLOTS - 1)) ? '0 : r_cur + 1'b1;
      r_cur_ch   <= (r_cur_ch == CHW'(CHANNELS - 1)) ? '0 : r_cur_ch + 1'b1;
      r_out_slot <= r_cur;
      r_out_zero <= (r_cur == '0);
      r_op_out   <= w_op_new;
      r_ch_out   <= w_ch_new;
    end
  end

  assign out_slot = r_out_slot;
  assign out_zero = r_out_zero;
  assign op_out   = r_op_out;
  assign ch_out   = r_ch_out;

endmodule

// File: tb/tb_jt12_regfile_q.sv
// Directed bench for jt12_regfile_q: default 6-channel build plus an 8-channel build.
module tb_jt12_regfile_q;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready, busy, out_zero;
  logic [2:0]  wr_ch;
  logic [1:0]  wr_op;
  logic [3:0]  wr_field;
  logic [7:0]  wr_data;
  logic [4:0]  out_slot;
  logic [43:0] op_out;
  logic [26:0] ch_out;

  logic        b_wr_valid, b_wr_ready, b_busy, b_out_zero;
  logic [2:0]  b_wr_ch;
  logic [1:0]  b_wr_op;
  logic [3:0]  b_wr_field;
  logic [7:0]  b_wr_data;
  logic [4:0]  b_out_slot;
  logic [43:0] b_op_out;
  logic [26:0] b_ch_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  jt12_regfile_q #(.CHANNELS(6), .QDEPTH(4), .CHW(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_op(wr_op), .wr_field(wr_field), .wr_data(wr_data),
    .busy(busy), .out_zero(out_zero), .out_slot(out_slot),
    .op_out(op_out), .ch_out(ch_out)
  );

  jt12_regfile_q #(.CHANNELS(8), .QDEPTH(4), .CHW(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_ch(b_wr_ch), .wr_op(b_wr_op), .wr_field(b_wr_field), .wr_data(b_wr_data),
    .busy(b_busy), .out_zero(b_out_zero), .out_slot(b_out_slot),
    .op_out(b_op_out), .ch_out(b_ch_out)
  );

  function automatic logic [43:0] tl_rec(input logic [6:0] v);
    return {3'd0, 4'd0, v, 30'd0};
  endfunction

  // Called at a negedge; returns at the negedge after the write was taken
  task automatic push_write(input logic [2:0] ch, input logic [1:0] op,
                            input logic [3:0] field, input logic [7:0] data);
    logic acc;
    logic done;
    done = 1'b0;
    wr_valid = 1'b1; wr_ch = ch; wr_op = op; wr_field = field; wr_data = data;
    for (int i = 0; i < 200 && !done; i++) begin
      acc = wr_ready;
      @(negedge clk);
      if (acc) done = 1'b1;
    end
    wr_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL push_timeout: write ch=%0d field=%0d never accepted", ch, field);
    end
  endtask

  task automatic wait_slot(input int s);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (out_slot == 5'(s)) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL wait_slot: out_slot=%0d, slot %0d never seen", out_slot, s);
    else n_pass++;
  endtask

  task automatic wait_idle(input int limit);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < limit && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    n_checks++;
    if (!idle) $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, limit);
    else n_pass++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_ch = '0; wr_op = '0; wr_field = '0; wr_data = '0;
    b_wr_valid = 1'b0; b_wr_ch = '0; b_wr_op = '0; b_wr_field = '0; b_wr_data = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({out_slot, out_zero, op_out, ch_out, busy, wr_ready} !== {5'd0, 1'b1, 44'd0, 27'd0, 1'b0, 1'b1})
      $display("FAIL reset_values: slot=%0d zero=%0b op=%h ch=%h busy=%0b rdy=%0b", out_slot, out_zero, op_out, ch_out, busy, wr_ready);
    else n_pass++;
    rst_n = 1'b1;
    for (int n = 0; n < 49; n++) begin
      @(negedge clk);
      n_checks++;
      if ({out_slot, out_zero, op_out, ch_out} !== {5'(n % 24), 1'(n % 24 == 0), 44'd0, 27'd0})
        $display("FAIL idle_walk[%0d]: slot=%0d zero=%0b op=%h ch=%h, required slot=%0d", n, out_slot, out_zero, op_out, ch_out, n % 24);
      else n_pass++;
      n_checks++;
      if ({b_out_slot, b_out_zero} !== {5'(n % 32), 1'(n % 32 == 0)})
        $display("FAIL idle_walk8[%0d]: slot=%0d zero=%0b, required slot=%0d", n, b_out_slot, b_out_zero, n % 32);
      else n_pass++;
    end
  endtask

  task automatic test_tl_write();
    push_write(3'd2, 2'd1, 4'd1, 8'h7F);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL tl_busy_rise: busy=%0b required 1", busy); else n_pass++;
    wait_slot(8);
    n_checks++;
    if ({op_out, busy} !== {tl_rec(7'h7F), 1'b0})
      $display("FAIL tl_slot8: op=%h busy=%0b, required op=%h busy=0", op_out, busy, tl_rec(7'h7F));
    else n_pass++;
    wait_slot(9);
    n_checks++;
    if (op_out !== 44'd0) $display("FAIL tl_slot9: op=%h required 0", op_out); else n_pass++;
    wait_slot(2);
    n_checks++;
    if (op_out !== 44'd0) $display("FAIL tl_slot2: op=%h required 0", op_out); else n_pass++;
    wait_slot(8);
    n_checks++;
    if (op_out !== tl_rec(7'h7F)) $display("FAIL tl_persist: op=%h required %h", op_out, tl_rec(7'h7F)); else n_pass++;
  endtask

  // Push to an empty queue commits the very next cycle, and the read shows it at once
  task automatic test_write_first();
    wait_slot(4);
    push_write(3'd0, 2'd1, 4'd0, 8'h35);
    n_checks++;
    if ({out_slot, busy} !== {5'd5, 1'b1}) $display("FAIL wf_head: slot=%0d busy=%0b, required 5/1", out_slot, busy); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_slot, op_out, busy} !== {5'd6, {3'd3, 4'd5, 37'd0}, 1'b0})
      $display("FAIL wf_read: slot=%0d op=%h busy=%0b, required slot=6 op=%h busy=0", out_slot, op_out, busy, {3'd3, 4'd5, 37'd0});
    else n_pass++;
  endtask

  task automatic test_channel_write();
    logic [26:0] exp;
    exp = {3'd5, 11'h455, 13'd0};
    push_write(3'd4, 2'd2, 4'd9, 8'h2C);
    push_write(3'd4, 2'd0, 4'd8, 8'h55);
    wait_idle(80);
    wait_slot(4);
    n_checks++;
    if (ch_out !== exp) $display("FAIL ch4_slot4: ch=%h required %h", ch_out, exp); else n_pass++;
    wait_slot(5);
    n_checks++;
    if (ch_out !== 27'd0) $display("FAIL ch5_slot5: ch=%h required 0", ch_out); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      wait_slot(4 + 6 * k);
      n_checks++;
      if (ch_out !== exp) $display("FAIL ch4_slot%0d: ch=%h required %h", 4 + 6 * k, ch_out, exp); else n_pass++;
    end
  endtask

  task automatic test_fields();
    logic [43:0] exp_op;
    logic [26:0] exp_ch;
    exp_op = {3'd7, 4'hF, 7'd0, 2'd3, 5'h1F, 1'b1, 5'h0A, 5'h13, 4'hA, 4'h6, 1'b1, 3'd5};
    exp_ch = {3'd0, 11'd0, 3'd7, 3'd7, 2'd3, 2'd1, 3'd3};
    push_write(3'd2, 2'd3, 4'd2, 8'hDF);
    push_write(3'd2, 2'd3, 4'd3, 8'h8A);
    push_write(3'd2, 2'd3, 4'd4, 8'h13);
    push_write(3'd2, 2'd3, 4'd5, 8'hA6);
    push_write(3'd2, 2'd3, 4'd6, 8'h0D);
    push_write(3'd2, 2'd3, 4'd0, 8'hFF);
    push_write(3'd3, 2'd1, 4'd10, 8'hFF);
    push_write(3'd3, 2'd0, 4'd11, 8'hDB);
    wait_idle(400);
    wait_slot(3);
    n_checks++;
    if (ch_out !== exp_ch) $display("FAIL fields_ch3: ch=%h required %h", ch_out, exp_ch); else n_pass++;
    wait_slot(20);
    n_checks++;
    if ({op_out, ch_out} !== {exp_op, 27'd0}) $display("FAIL fields_slot20: op=%h ch=%h required op=%h ch=0", op_out, ch_out, exp_op); else n_pass++;
    wait_slot(21);
    n_checks++;
    if (ch_out !== exp_ch) $display("FAIL fields_slot21: ch=%h required %h", ch_out, exp_ch); else n_pass++;
  endtask

  // Four pushes fill the queue; the fifth waits until the first pop at slot 13
  task automatic test_back_to_back();
    logic acc;
    logic done;
    int   waits;
    wait_slot(13);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_ch = 3'd1; wr_op = 2'd2; wr_field = 4'd1; wr_data = 8'(i + 1);
      n_checks++;
      if (wr_ready !== 1'b1) $display("FAIL burst_ready[%0d]: wr_ready=%0b required 1", i, wr_ready); else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({wr_ready, busy} !== 2'b01) $display("FAIL burst_full: wr_ready=%0b busy=%0b, required 0/1", wr_ready, busy); else n_pass++;
    wr_data = 8'd5;
    waits = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      acc = wr_ready;
      @(negedge clk);
      if (acc) done = 1'b1;
      else begin
        waits++;
        if (out_slot == 5'd13) begin
          n_checks++;
          if (op_out !== tl_rec(7'd1)) $display("FAIL burst_commit1: op=%h required %h", op_out, tl_rec(7'd1)); else n_pass++;
        end
      end
    end
    wr_valid = 1'b0;
    n_checks++;
    if (waits != 20) $display("FAIL burst_fifth_wait: waited %0d cycles, required 20", waits); else n_pass++;
    for (int k = 2; k <= 5; k++) begin
      wait_slot(13);
      n_checks++;
      if (op_out !== tl_rec(7'(k))) $display("FAIL burst_commit%0d: op=%h required %h", k, op_out, tl_rec(7'(k))); else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL burst_drained: busy=%0b required 0", busy); else n_pass++;
  endtask

  task automatic test_invalid();
    wr_valid = 1'b1; wr_ch = 3'd7; wr_op = 2'd0; wr_field = 4'd1; wr_data = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL inv_busy0: busy=%0b required 1", busy); else n_pass++;
    wr_ch = 3'd0; wr_field = 4'd15;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL inv_busy1: busy=%0b required 1", busy); else n_pass++;
    wr_ch = 3'd1; wr_field = 4'd7;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL inv_busy2: busy=%0b required 1", busy); else n_pass++;
    wr_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, wr_ready} !== 2'b01) $display("FAIL inv_drained: busy=%0b wr_ready=%0b, required 0/1", busy, wr_ready); else n_pass++;
    wait_slot(0);
    n_checks++;
    if ({op_out, ch_out} !== 71'd0) $display("FAIL inv_slot0: op=%h ch=%h required 0", op_out, ch_out); else n_pass++;
    wait_slot(1);
    n_checks++;
    if ({op_out, ch_out} !== 71'd0) $display("FAIL inv_slot1: op=%h ch=%h required 0", op_out, ch_out); else n_pass++;
    wait_slot(7);
    n_checks++;
    if (op_out !== 44'd0) $display("FAIL inv_slot7: op=%h required 0", op_out); else n_pass++;
  endtask

  task automatic test_ch8();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (b_out_slot == 5'd0) found = 1'b1;
    end
    b_wr_valid = 1'b1; b_wr_ch = 3'd7; b_wr_op = 2'd3; b_wr_field = 4'd1; b_wr_data = 8'h2A;
    @(negedge clk);
    b_wr_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (b_out_slot == 5'd31) found = 1'b1;
    end
    n_checks++;
    if (!found || {b_op_out, b_ch_out, b_busy} !== {tl_rec(7'h2A), 27'd0, 1'b0})
      $display("FAIL ch8_slot31: seen=%0b op=%h ch=%h busy=%0b, required op=%h", found, b_op_out, b_ch_out, b_busy, tl_rec(7'h2A));
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({b_out_slot, b_out_zero, b_op_out} !== {5'd0, 1'b1, 44'd0})
      $display("FAIL ch8_wrap: slot=%0d zero=%0b op=%h, required 0/1/0", b_out_slot, b_out_zero, b_op_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    wait_slot(0);
    push_write(3'd5, 2'd3, 4'd1, 8'd1);
    push_write(3'd5, 2'd3, 4'd1, 8'd2);
    push_write(3'd5, 2'd3, 4'd1, 8'd3);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rmid_busy_before: busy=%0b required 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, wr_ready, out_slot, out_zero, op_out, ch_out} !== {1'b0, 1'b1, 5'd0, 1'b1, 44'd0, 27'd0})
      $display("FAIL rmid_async: busy=%0b rdy=%0b slot=%0d zero=%0b op=%h ch=%h", busy, wr_ready, out_slot, out_zero, op_out, ch_out);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 48; n++) begin
      @(negedge clk);
      n_checks++;
      if ({out_slot, op_out, ch_out, busy} !== {5'(n % 24), 44'd0, 27'd0, 1'b0})
        $display("FAIL rmid_clean[%0d]: slot=%0d op=%h ch=%h busy=%0b", n, out_slot, op_out, ch_out, busy);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_tl_write();
    test_write_first();
    test_channel_write();
    test_fields();
    test_back_to_back();
    test_invalid();
    test_ch8();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
